// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer slice.
// Holds the sequencer FSM state type, the fixed instruction size and the
// default reset/trap vectors used as parameter defaults by pc_sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Every instruction is 4 bytes; sequential fetch advances by this amount.
  localparam int INSN_BYTES = 4;

  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
  localparam logic [63:0] DEFAULT_TRAP_VECTOR  = 64'h100;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack used by pc_sequencer when the
// PC_SEQ_RAS_EN build macro is defined.
// - push on a full stack overwrites the oldest entry (pointer just wraps)
// - pop on an empty stack is ignored; the caller checks 'empty'
// - push together with pop replaces the top entry, depth unchanged
//   (on an empty stack this degenerates to a plain push)
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  // Entry storage carries no reset: a zero count already hides stale data.
  logic [XLEN-1:0] entry_mem [RAS_DEPTH];

  // wr_ptr_reg points at the next free slot; the top entry sits just below it.
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             full;
  logic             do_pop;

  assign top_idx = wr_ptr_reg - PTR_W'(1);
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(RAS_DEPTH));
  assign top     = entry_mem[top_idx];
  assign do_pop  = pop & ~empty;

  // Next pointer/count and the slot to write for this cycle's operation.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    wr_idx      = wr_ptr_reg;
    if (push && do_pop) begin
      wr_idx = top_idx;
    end else if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (!full) begin
        count_next = count_reg + (PTR_W+1)'(1);
      end
    end else if (do_pop) begin
      wr_ptr_next = top_idx;
      count_next  = count_reg - (PTR_W+1)'(1);
    end
  end

  // Stack pointer and occupancy; reset empties the stack immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry write; suppressed while reset is high so no push lands during it.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      entry_mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with BOOT/RUN/HALT control,
// trap/mret handling, misaligned-target detection and an optional
// return-address stack.
// Build macro PC_SEQ_RAS_EN: when defined, a pc_ras instance is compiled in
// and ras_push/ras_pop act on it; when undefined they are ignored and no
// stack storage exists.
// Next-PC priority in RUN: trap > halt_req > mret > redirect > stall > pc+4.
// halt_req freezes pc for the cycle it is accepted; a trap in the same
// cycle wins and the sequencer stays in RUN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            fetch_valid,
  output logic            misaligned
);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] epc_reg, epc_next;
  logic            fetch_valid_reg;
  logic            misaligned_reg, misaligned_next;

  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_push_en;
  logic            ras_pop_en;
  logic            use_ras_top;
  logic [XLEN-1:0] redir_target;

  assign pc          = pc_reg;
  assign epc         = epc_reg;
  assign fetch_valid = fetch_valid_reg;
  assign misaligned  = misaligned_reg;
  assign pc_plus4    = pc_reg + XLEN'(INSN_BYTES);

  // A stalled cycle never touches the stack, so a stalled pop falls back
  // to redirect_target.
  assign use_ras_top  = ras_pop & ~stall & ~ras_empty;
  assign redir_target = use_ras_top ? ras_top : redirect_target;

`ifdef PC_SEQ_RAS_EN
  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_en),
    .pop       (ras_pop_en),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  // No stack: it always looks empty, so redirect_target is always used.
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign unused_ras = ras_push_en ^ ras_pop_en;
`endif

  // Next state, next PC/EPC, misaligned pulse and stack operations.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    epc_next        = epc_reg;
    misaligned_next = 1'b0;
    ras_push_en     = 1'b0;
    ras_pop_en      = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (trap) begin
          pc_next  = TRAP_VECTOR;
          epc_next = pc_reg;
        end else if (halt_req) begin
          state_next = ST_HALT;
        end else if (mret) begin
          if (epc_reg[1:0] != 2'b00) begin
            pc_next         = TRAP_VECTOR;
            epc_next        = pc_reg;
            misaligned_next = 1'b1;
          end else begin
            pc_next = epc_reg;
          end
        end else if (redirect_valid) begin
          if (redir_target[1:0] != 2'b00) begin
            // Behaves like a trap: stack left untouched.
            pc_next         = TRAP_VECTOR;
            epc_next        = pc_reg;
            misaligned_next = 1'b1;
          end else begin
            pc_next     = redir_target;
            ras_push_en = ras_push & ~stall;
            ras_pop_en  = ras_pop & ~stall;
          end
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
      end
      ST_HALT: begin
        if (trap) begin
          state_next = ST_RUN;
          pc_next    = TRAP_VECTOR;
          epc_next   = pc_reg;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State and registered outputs; reset returns everything to BOOT at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_BOOT;
      pc_reg          <= RESET_VECTOR;
      epc_reg         <= '0;
      fetch_valid_reg <= 1'b0;
      misaligned_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      epc_reg         <= epc_next;
      fetch_valid_reg <= (state_next == ST_RUN);
      misaligned_reg  <= misaligned_next;
    end
  end

endmodule
